// File: rtl/seq_det_pkg.sv
// Shared types, reset defaults and helpers for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned LEN_CALC_W = 5;

  // Reset configuration: detect "101" with overlap.
  localparam logic [15:0] DEF_PAT = 16'h0005;
  localparam int unsigned DEF_LEN = 3;

  // Map a requested length into the legal 1..max_len range.
  function automatic logic [LEN_CALC_W-1:0] clamp_len(input logic [LEN_CALC_W-1:0] len,
                                                      input logic [LEN_CALC_W-1:0] max_len);
    logic [LEN_CALC_W-1:0] r;
    r = len;
    if (len == '0) r = LEN_CALC_W'(1);
    else if (len > max_len) r = max_len;
    return r;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Shift history, fill tracking and masked pattern compare; hit_c is combinational.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               x,
  input  logic [PAT_MAX-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit_c
);

  logic [PAT_MAX-1:0] hist;
  logic [PAT_MAX-1:0] hist_next;
  logic [PAT_MAX-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_next;

  // Candidate history/fill if the current sample is accepted.
  assign hist_next = {hist[PAT_MAX-2:0], x};
  assign fill_next = (fill >= len) ? len : fill + LEN_W'(1);
  assign mask      = ~({PAT_MAX{1'b1}} << len);
  assign hit_c     = shift_en && (fill_next == len) && (((hist_next ^ pat) & mask) == '0);

  // History and fill update; a non-overlapping hit restarts the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_next;
      fill <= (hit_c && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector: config, arm/abort FSM, match counting and irq.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               start,
  input  logic               stop,
  input  logic               x_valid,
  input  logic               x,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               irq,
  output logic               done
);

  state_t             state;
  state_t             state_next;
  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   thr_q;

  logic               cfg_load_c;
  logic               run_clr_c;
  logic               shift_en_c;
  logic               hit_c;
  logic               thresh_hit_c;
  logic [CNT_W-1:0]   cnt_sat_c;
  logic [LEN_W-1:0]   len_clamped_c;

  assign len_clamped_c = LEN_W'(clamp_len(LEN_CALC_W'(cfg_len), LEN_CALC_W'(PAT_MAX)));
  assign shift_en_c    = (state == RUN) && x_valid;
  assign cnt_sat_c     = (match_cnt == {CNT_W{1'b1}}) ? match_cnt : match_cnt + CNT_W'(1);
  assign thresh_hit_c  = hit_c && (thr_q != '0) && (cnt_sat_c == thr_q);

  seq_match_core #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (run_clr_c),
    .shift_en (shift_en_c),
    .x        (x),
    .pat      (pat_q),
    .len      (len_q),
    .overlap  (ovl_q),
    .hit_c    (hit_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and control strobes; stop outranks the threshold transition.
  always_comb begin
    state_next = state;
    cfg_load_c = 1'b0;
    run_clr_c  = 1'b0;
    case (state)
      IDLE: begin
        cfg_load_c = cfg_we;
        if (start) begin
          state_next = RUN;
          run_clr_c  = 1'b1;
        end
      end
      RUN: begin
        if (stop)              state_next = IDLE;
        else if (thresh_hit_c) state_next = DONE;
      end
      DONE: begin
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          state_next = RUN;
          run_clr_c  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= PAT_MAX'(DEF_PAT);
      len_q <= LEN_W'(DEF_LEN);
      ovl_q <= 1'b1;
      thr_q <= '0;
    end else if (cfg_load_c) begin
      pat_q <= cfg_pat;
      len_q <= len_clamped_c;
      ovl_q <= cfg_overlap;
      thr_q <= cfg_thresh;
    end
  end

  // Registered outputs: pulses, saturating counter and state decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match     <= 1'b0;
      irq       <= 1'b0;
      match_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      match <= hit_c;
      irq   <= thresh_hit_c;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      if (run_clr_c)  match_cnt <= '0;
      else if (hit_c) match_cnt <= cnt_sat_c;
    end
  end

endmodule
